read_burst: RTL
===============

READ_BURST -- requirements
Module: read_burst

Interface
REQ-001 SHALL have parameter BEATS, default 6, meaning 128-bit beats per burst (768 / 128).
REQ-002 SHALL have parameter CMD_READ, default 3'b001, meaning the memory-port read command code.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port read, input, 1, one-cycle request to start a burst read.
REQ-006 SHALL have port address_in, input, 31, start address of the burst, sampled with read.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted read until return to IDLE.
REQ-008 SHALL have port address_enable, output, 1, command strobe to the memory port.
REQ-009 SHALL have port read_command, output, 3, command code presented with address_enable.
REQ-010 SHALL have port address_out, output, 31, burst address presented with address_enable.
REQ-011 SHALL have port burst_length, output, 6, constant BEATS-1 (5 for default).
REQ-012 SHALL have port command_full, input, 1, memory command queue full; blocks address_enable.
REQ-013 SHALL have port read_empty, input, 1, memory read-data FIFO empty.
REQ-014 SHALL have port read_data_in, input, 128, memory read-data FIFO head word.
REQ-015 SHALL have port read_enable, output, 1, pop strobe to the read-data FIFO.
REQ-016 SHALL have port data_out, output, 768, assembled burst result.
REQ-017 SHALL have port data_valid, output, 1, one-cycle pulse marking data_out updated.

Function
REQ-018 SHALL implement states IDLE, CMD, COLLECT, DONE.
REQ-019 SHALL in IDLE with read=1 latch address_in, clear beat counter, go to CMD; busy=1 from next cycle.
REQ-020 SHALL ignore read in any state other than IDLE (no re-latch, no queued request).
REQ-021 SHALL in CMD drive address_enable=1 combinationally only while command_full=0, with read_command=CMD_READ and address_out=latched address; go to COLLECT on that edge.
REQ-022 SHALL in CMD with command_full=1 hold address_enable=0 and remain in CMD indefinitely.
REQ-023 SHALL drive read_command=3'b000 and address_enable=0 outside CMD; address_out holds latched address.
REQ-024 SHALL in COLLECT drive read_enable = !read_empty combinationally; read_enable=0 in all other states.
REQ-025 SHALL on each edge with read_enable=1 store read_data_in into internal assembly register slice [128*k+127:128*k], k = beat counter, then increment k.
REQ-026 SHALL order beats least-significant first: beat 0 -> bits 127:0, beat 5 -> bits 767:640.
REQ-027 SHALL go to DONE on the edge that captures beat BEATS-1; read_enable=0 after that edge.
REQ-028 SHALL tolerate read_empty gaps of any length between beats without losing or duplicating beats.
REQ-029 SHALL in DONE copy the assembly register to data_out, pulse data_valid for exactly one cycle, and return to IDLE.
REQ-030 SHALL hold data_out stable between data_valid pulses; partial bursts never visible on data_out.
REQ-031 SHALL deassert busy the cycle after data_valid; a new read is accepted in that IDLE cycle.
REQ-032 SHALL give minimum latency read -> data_valid of 2+BEATS+1 cycles (9 for default) with no stalls.
REQ-033 SHALL keep beat counter width ceil(log2(BEATS+1)); no wrap within a burst.

Reset
REQ-034 SHALL on reset=0, at any time including mid-burst, go to IDLE immediately: busy=0, address_enable=0, read_enable=0, read_command=0, address_out=0, data_out=0, data_valid=0, counter=0.
REQ-035 SHALL not complete or report an aborted burst after reset release; remaining FIFO words are not popped.

Verification
REQ-036 SHALL verify basic burst: reset, read=1 with address_in=31'd1, FIFO supplies 128'd1..128'd6 with read_empty=0 -> one address_enable with address_out=1, read_command=3'b001, six read_enable pulses, data_valid once 9 cycles after read, data_out = {128'd6,...,128'd1}.
REQ-037 SHALL verify command back-pressure: command_full=1 for 4 cycles after read -> address_enable stays 0 for those cycles, then one pulse; result unchanged.
REQ-038 SHALL verify FIFO gaps: read_empty=1 for 3 cycles between beats 2 and 3 -> no read_enable during gap, data_out still correct, data_valid delayed 3 cycles.
REQ-039 SHALL verify request while busy: second read with address_in=31'd7 during COLLECT -> ignored, address_out remains 1, only one burst.
REQ-040 SHALL verify reset mid-burst: reset=0 after beat 3 -> all outputs zero same cycle, no data_valid afterwards; subsequent read of address 31'd2 completes normally.

Source files
------------

// File: rtl/read_burst.sv
// Burst reader: issues one read command to a memory port, then collects BEATS
// 128-bit words from the read-data FIFO (least-significant beat first) and
// presents the assembled result on data_out with a one-cycle data_valid pulse.
module read_burst #(
  parameter int unsigned BEATS    = 6,
  parameter logic [2:0]  CMD_READ = 3'b001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read,
  input  logic [30:0]            address_in,
  output logic                   busy,
  output logic                   address_enable,
  output logic [2:0]             read_command,
  output logic [30:0]            address_out,
  output logic [5:0]             burst_length,
  input  logic                   command_full,
  input  logic                   read_empty,
  input  logic [127:0]           read_data_in,
  output logic                   read_enable,
  output logic [128*BEATS-1:0]   data_out,
  output logic                   data_valid
);

  localparam int unsigned CntW = $clog2(BEATS + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCmd     = 2'd1;
  localparam logic [1:0] StCollect = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [30:0]          addr_q, addr_d;
  logic [128*BEATS-1:0] asm_q, asm_d;
  logic [128*BEATS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 accept;

  assign burst_length = 6'(BEATS - 1);
  assign address_out  = addr_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  // Busy stays high through the data_valid cycle so a new request lands one cycle later.
  assign busy         = (state_q != StIdle) || data_valid_q;
  assign accept       = (state_q == StIdle) && !data_valid_q && read;

  // Next-state decode and combinational memory-port strobes.
  always_comb begin
    state_d        = state_q;
    address_enable = 1'b0;
    read_command   = 3'b000;
    read_enable    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCmd;
      end
      StCmd: begin
        if (!command_full) begin
          address_enable = 1'b1;
          read_command   = CMD_READ;
          state_d        = StCollect;
        end
      end
      StCollect: begin
        read_enable = !read_empty;
        if (!read_empty && (cnt_q == CntW'(BEATS - 1))) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: address latch, beat counter, assembly and result registers.
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (accept) begin
      addr_d = address_in;
      cnt_d  = '0;
    end
    if (read_enable) begin
      asm_d[128*cnt_q +: 128] = read_data_in;
      cnt_d                   = cnt_q + CntW'(1);
    end
    if (state_q == StDone) begin
      data_out_d   = asm_q;
      data_valid_d = 1'b1;
    end
  end

  // State registers; asynchronous reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule
